// File: rtl/uart_fifo_bridge_pkg.sv
// Shared types for the UART FIFO bridge: TX pump states and RX entry width.
// RX entries carry a framing-error tag only when UART_RX_ERRTAG_EN is defined.
package uart_fifo_bridge_pkg;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_STROBE = 2'd1,
        TX_BUSY   = 2'd2
    } tx_state_e;

`ifdef UART_RX_ERRTAG_EN
    localparam int RX_W = 9;
`else
    localparam int RX_W = 8;
`endif

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      din_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      dout_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        if (do_pop && !do_push) count_d = count_q - (DEPTH_LOG2 + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Byte buffering between host logic and UART_core, TX pump FSM and RX drain.
// Define UART_RX_ERRTAG_EN to store a framing-error tag with each RX byte.
module uart_fifo_bridge
    import uart_fifo_bridge_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            tx_data,
    input  logic                  tx_wr,
    output logic                  tx_full,
    output logic                  tx_empty,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic [7:0]            rx_data,
    input  logic                  rx_rd,
    output logic                  rx_empty,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  rx_ovf,
    input  logic                  rx_ovf_clr,
    output logic                  rx_frame_err,
    output logic [7:0]            u_d,
    output logic                  u_wr,
    input  logic                  u_txrdy,
    input  logic [7:0]            u_q,
    input  logic                  u_rxvalid,
    input  logic                  u_rxframeer,
    output logic                  u_rd
);

    tx_state_e        state_q;
    logic [7:0]       u_d_q;
    logic             u_wr_q;
    logic             u_rd_q, u_rd_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       tx_head;
    logic             tx_fifo_empty, tx_pop;
    logic [RX_W-1:0]  rx_din, rx_head;
    logic             rx_full, rx_push, rx_pop;

    uart_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_wr),
        .din_i   (tx_data),
        .pop_i   (tx_pop),
        .dout_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_fifo_empty),
        .count_o (tx_count)
    );

    assign tx_pop   = (state_q == TX_IDLE) && !tx_fifo_empty && u_txrdy;
    assign tx_empty = tx_fifo_empty && (state_q == TX_IDLE);
    assign u_d      = u_d_q;
    assign u_wr     = u_wr_q;

    // u_wr rises together with the STROBE state, so it is high only there.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= TX_IDLE;
            u_d_q   <= '0;
            u_wr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                TX_IDLE: begin
                    if (tx_pop) begin
                        u_d_q   <= tx_head;
                        u_wr_q  <= 1'b1;
                        state_q <= TX_STROBE;
                    end
                end
                TX_STROBE: begin
                    u_wr_q  <= 1'b0;
                    state_q <= TX_BUSY;
                end
                TX_BUSY: begin
                    if (u_txrdy) state_q <= TX_IDLE;
                end
                default: begin
                    u_wr_q  <= 1'b0;
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

`ifdef UART_RX_ERRTAG_EN
    assign rx_din       = {u_rxframeer, u_q};
    assign rx_frame_err = rx_head[8];
`else
    logic unused_frameer;
    assign unused_frameer = u_rxframeer;
    assign rx_din         = u_q;
    assign rx_frame_err   = 1'b0;
`endif

    uart_sync_fifo #(.WIDTH(RX_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .din_i   (rx_din),
        .pop_i   (rx_rd),
        .dout_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    // Gating on u_rd avoids a second push while the core clears rxvalid.
    assign rx_push = u_rxvalid && !u_rd_q;
    assign rx_pop  = rx_rd && !rx_empty;
    assign rx_data = rx_head[7:0];
    assign u_rd    = u_rd_q;
    assign rx_ovf  = ovf_q;

    always_comb begin
        u_rd_d = rx_push;
        ovf_d  = ovf_q;
        if (rx_ovf_clr) ovf_d = 1'b0;
        if (rx_push && rx_full && !rx_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            u_rd_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            u_rd_q <= u_rd_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Randomized and directed bench for uart_fifo_bridge against a queue model.
// Build with UART_RX_ERRTAG_EN defined to exercise the RX error tag.
module tb_uart_fifo_bridge;

    localparam int DL = 4;
    localparam int CAP = 1 << DL;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_wr = 1'b0;
    logic        tx_full, tx_empty;
    logic [DL:0] tx_count, rx_count;
    logic [7:0]  rx_data;
    logic        rx_rd = 1'b0;
    logic        rx_empty, rx_ovf, rx_frame_err;
    logic        rx_ovf_clr = 1'b0;
    logic [7:0]  u_d;
    logic        u_wr, u_rd;
    logic        u_txrdy = 1'b0;
    logic [7:0]  u_q = '0;
    logic        u_rxvalid = 1'b0;
    logic        u_rxframeer = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model state
    logic [7:0] txq[$];
    logic [8:0] rxq[$];
    int         ph = 0;
    logic [7:0] m_d = '0;
    logic       m_wr = 1'b0;
    logic       m_rd = 1'b0;
    logic       m_ovf = 1'b0;

    uart_fifo_bridge #(.DEPTH_LOG2(DL)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_data      (tx_data),
        .tx_wr        (tx_wr),
        .tx_full      (tx_full),
        .tx_empty     (tx_empty),
        .tx_count     (tx_count),
        .rx_data      (rx_data),
        .rx_rd        (rx_rd),
        .rx_empty     (rx_empty),
        .rx_count     (rx_count),
        .rx_ovf       (rx_ovf),
        .rx_ovf_clr   (rx_ovf_clr),
        .rx_frame_err (rx_frame_err),
        .u_d          (u_d),
        .u_wr         (u_wr),
        .u_txrdy      (u_txrdy),
        .u_q          (u_q),
        .u_rxvalid    (u_rxvalid),
        .u_rxframeer  (u_rxframeer),
        .u_rd         (u_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic wr_n;
        logic push_now;
        logic drop;
        wr_n = 1'b0;
        drop = 1'b0;
        if (!reset) begin
            txq.delete();
            rxq.delete();
            ph = 0;
            m_d = '0;
            m_wr = 1'b0;
            m_rd = 1'b0;
            m_ovf = 1'b0;
        end else begin
            // pump: 0 idle, 1 strobe, 2 busy
            if (ph == 0) begin
                if (txq.size() > 0 && u_txrdy) begin
                    m_d = txq.pop_front();
                    wr_n = 1'b1;
                    ph = 1;
                end
            end else if (ph == 1) begin
                ph = 2;
            end else if (u_txrdy) begin
                ph = 0;
            end
            if (tx_wr && txq.size() < CAP) txq.push_back(tx_data);
            m_wr = wr_n;
            if (rx_rd && rxq.size() > 0) void'(rxq.pop_front());
            push_now = u_rxvalid && !m_rd;
            if (push_now) begin
                if (rxq.size() < CAP) rxq.push_back({u_rxframeer, u_q});
                else drop = 1'b1;
            end
            m_rd = push_now;
            if (drop) m_ovf = 1'b1;
            else if (rx_ovf_clr) m_ovf = 1'b0;
        end
    endtask

    task automatic compare();
        chk("tx_count", 32'(tx_count), 32'(txq.size()));
        chk("tx_full", 32'(tx_full), 32'(txq.size() == CAP));
        chk("tx_empty", 32'(tx_empty), 32'(txq.size() == 0 && ph == 0));
        chk("u_wr", 32'(u_wr), 32'(m_wr));
        chk("u_d", 32'(u_d), 32'(m_d));
        chk("u_rd", 32'(u_rd), 32'(m_rd));
        chk("rx_count", 32'(rx_count), 32'(rxq.size()));
        chk("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
        chk("rx_ovf", 32'(rx_ovf), 32'(m_ovf));
        if (rxq.size() > 0) begin
            chk("rx_data", 32'(rx_data), 32'(rxq[0][7:0]));
`ifdef UART_RX_ERRTAG_EN
            chk("rx_frame_err", 32'(rx_frame_err), 32'(rxq[0][8]));
`else
            chk("rx_frame_err", 32'(rx_frame_err), 32'd0);
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic quiet();
        tx_wr = 1'b0;
        rx_rd = 1'b0;
        rx_ovf_clr = 1'b0;
        u_rxvalid = 1'b0;
        u_rxframeer = 1'b0;
        u_txrdy = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] got[3];
        int n;
        int busy;
        int guard;

        // reset held with tx_wr asserted
        reset = 1'b0;
        tx_wr = 1'b1;
        tx_data = 8'h77;
        step();
        step();
        chk("rst_tx_count", 32'(tx_count), 32'd0);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
        chk("rst_tx_empty", 32'(tx_empty), 32'd1);
        chk("rst_rx_empty", 32'(rx_empty), 32'd1);
        chk("rst_u_wr", 32'(u_wr), 32'd0);
        chk("rst_u_rd", 32'(u_rd), 32'd0);
        chk("rst_u_d", 32'(u_d), 32'd0);
        chk("rst_rx_ovf", 32'(rx_ovf), 32'd0);
        reset = 1'b1;
        quiet();

        // TX burst with a core that drops txrdy for a frame after each wr
        u_txrdy = 1'b1;
        n = 0;
        busy = 0;
        for (int i = 0; i < 80; i++) begin
            tx_wr = (i < 3);
            tx_data = (i == 0) ? 8'h55 : (i == 1) ? 8'hA3 : 8'h0F;
            step();
            if (u_wr) begin
                if (n < 3) got[n] = u_d;
                n++;
                busy = 6;
            end
            u_txrdy = (busy == 0);
            if (busy > 0) busy--;
        end
        tx_wr = 1'b0;
        chk("burst_pulses", 32'(n), 32'd3);
        chk("burst_b0", 32'(got[0]), 32'h55);
        chk("burst_b1", 32'(got[1]), 32'hA3);
        chk("burst_b2", 32'(got[2]), 32'h0F);
        chk("burst_tx_empty", 32'(tx_empty), 32'd1);

        // TX full with the core never ready
        do_reset();
        u_txrdy = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tx_wr = 1'b1;
            tx_data = 8'h10 + 8'(i);
            step();
            if (i == 15) chk("full_after_16", 32'(tx_full), 32'd1);
        end
        tx_wr = 1'b0;
        step();
        chk("full_count", 32'(tx_count), 32'd16);
        u_txrdy = 1'b1;
        step();
        chk("full_first_wr", 32'(u_wr), 32'd1);
        chk("full_first_d", 32'(u_d), 32'h10);
        u_txrdy = 1'b0;
        step();

        // RX drain: valid held across the u_rd cycle
        do_reset();
        u_rxvalid = 1'b1;
        u_q = 8'h3C;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!u_rd && guard < 5);
        chk("drain_rd_seen", 32'(u_rd), 32'd1);
        step();
        u_rxvalid = 1'b0;
        chk("drain_rd_pulse", 32'(u_rd), 32'd0);
        chk("drain_count", 32'(rx_count), 32'd1);
        chk("drain_data", 32'(rx_data), 32'h3C);

        // RX overflow: 17 bytes, no host pop
        do_reset();
        for (int i = 0; i < 17; i++) begin
            u_rxvalid = 1'b1;
            u_q = 8'hA0 + 8'(i);
            step();
            u_rxvalid = 1'b0;
            step();
        end
        chk("ovf_flag", 32'(rx_ovf), 32'd1);
        chk("ovf_count", 32'(rx_count), 32'd16);
        chk("ovf_head", 32'(rx_data), 32'hA0);
        rx_ovf_clr = 1'b1;
        step();
        rx_ovf_clr = 1'b0;
        chk("ovf_clr", 32'(rx_ovf), 32'd0);

        // framing-error tag
        do_reset();
        u_rxvalid = 1'b1;
        u_rxframeer = 1'b1;
        u_q = 8'h00;
        step();
        u_rxvalid = 1'b0;
        u_rxframeer = 1'b0;
        step();
        chk("tag_data", 32'(rx_data), 32'h00);
`ifdef UART_RX_ERRTAG_EN
        chk("tag_err", 32'(rx_frame_err), 32'd1);
`else
        chk("tag_err", 32'(rx_frame_err), 32'd0);
`endif

        // random traffic: balanced phase, then a slow host phase
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 599) != 0);
            tx_data = 8'($urandom);
            u_q = 8'($urandom);
            u_rxframeer = ($urandom_range(0, 3) == 0);
            rx_ovf_clr = ($urandom_range(0, 15) == 0);
            u_rxvalid = ($urandom_range(0, 1) == 1);
            if (i < 2000) begin
                tx_wr = ($urandom_range(0, 2) == 0);
                u_txrdy = ($urandom_range(0, 3) != 0);
                rx_rd = ($urandom_range(0, 1) == 1);
            end else begin
                tx_wr = ($urandom_range(0, 1) == 1);
                u_txrdy = ($urandom_range(0, 7) == 0);
                rx_rd = ($urandom_range(0, 7) == 0);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
